// File: rtl/parity_tx_if.sv
// Handshake and serial-output bundle for the parity transmitter.
// The master drives words and the bit-rate strobe; the slave is the transmitter.
interface parity_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              bit_en;
    logic              tx_bit;
    logic              tx_valid;
    logic              tx_last;
    logic              busy;

    modport master (
        output in_valid, in_data, bit_en,
        input  in_ready, tx_bit, tx_valid, tx_last, busy
    );

    modport slave (
        input  in_valid, in_data, bit_en,
        output in_ready, tx_bit, tx_valid, tx_last, busy
    );
endinterface

// File: rtl/parity_tx.sv
// Serial parity transmitter: shifts a parallel word out LSB first, then one parity bit.
// Outputs are decoded only from registered state, so no input reaches an output combinationally.
module parity_tx #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    parity_tx_if.slave  bus
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] shreg_r, shreg_s;
    logic [CNT_W-1:0]  cnt_r,   cnt_s;
    logic              par_r,   par_s;

    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            shreg_r <= '0;
            cnt_r   <= '0;
            par_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
            par_r   <= par_s;
        end
    end

    // Next-state and datapath update; bit_en gates every advance after acceptance
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
        par_s   = par_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_s = bus.in_data;
                    cnt_s   = '0;
                    par_s   = parity_of(bus.in_data, ODD_PARITY);
                    state_s = DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (bus.bit_en) begin
                    shreg_s = {1'b0, shreg_r[DATA_W-1:1]};
                    // Counter parks at its last value so it never exceeds DATA_W-1
                    if (cnt_r == CNT_LAST) begin
                        state_s = PAR;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PAR: begin
                if (bus.bit_en) begin
                    state_s = IDLE;
                end else begin
                    state_s = PAR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        bus.in_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_last  = 1'b0;
        bus.tx_bit   = 1'b0;
        bus.busy     = 1'b1;
        case (state_r)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            DATA: begin
                bus.tx_valid = 1'b1;
                bus.tx_bit   = shreg_r[0];
            end
            PAR: begin
                bus.tx_valid = 1'b1;
                bus.tx_last  = 1'b1;
                bus.tx_bit   = par_r;
            end
            default: begin
                bus.in_ready = 1'b0;
                bus.busy     = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx: an even-mode and an odd-mode instance run in lockstep
// on the same stimulus, with a serial parity checker model accumulated from the gated bits.
module tb_parity_tx;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    parity_tx_if #(.DATA_W(W)) if_e ();
    parity_tx_if #(.DATA_W(W)) if_o ();

    assign if_o.in_valid = if_e.in_valid;
    assign if_o.in_data  = if_e.in_data;
    assign if_o.bit_en   = if_e.bit_en;

    parity_tx #(.DATA_W(W), .ODD_PARITY(1'b0)) u_even (.clk(clk), .reset(reset), .bus(if_e));
    parity_tx #(.DATA_W(W), .ODD_PARITY(1'b1)) u_odd  (.clk(clk), .reset(reset), .bus(if_o));

    int   n_vec = 0;
    int   n_err = 0;
    logic z_e, z_o;

    typedef struct {
        logic [7:0] data;
        int         period;
        logic       pe;
        logic       po;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_ready"}, 8'(if_e.in_ready), 8'h1);
        chk({tag, "_valid"}, 8'(if_e.tx_valid), 8'h0);
        chk({tag, "_bit"},   8'(if_e.tx_bit),   8'h0);
        chk({tag, "_last"},  8'(if_e.tx_last),  8'h0);
        chk({tag, "_busy"},  8'(if_e.busy),     8'h0);
        chk({tag, "_ovalid"}, 8'(if_o.tx_valid), 8'h0);
    endtask

    // Wait (bounded) for in_ready, present the word, leave in_valid high just after the accepting edge
    task automatic start(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!if_e.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 8'(if_e.in_ready), 8'h1);
        if_e.bit_en   = 1'b0;
        if_e.in_valid = 1'b1;
        if_e.in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Check one whole frame cycle by cycle, with bit_en high on every period-th cycle
    task automatic body(input logic [7:0] d, input int period, input logic pe, input logic po);
        z_e = 1'b0;
        z_o = 1'b0;
        for (int k = 0; k <= W; k++) begin
            for (int j = 0; j < period; j++) begin
                @(negedge clk);
                if_e.bit_en = (j == period - 1);
                chk("tx_valid", 8'(if_e.tx_valid), 8'h1);
                chk("tx_last",  8'(if_e.tx_last),  8'(k == W));
                chk("tx_bit",   8'(if_e.tx_bit),   8'((k < W) ? d[k] : pe));
                chk("odd_bit",  8'(if_o.tx_bit),   8'((k < W) ? d[k] : po));
                chk("ready_busy", 8'(if_e.in_ready), 8'h0);
                chk("busy",     8'(if_e.busy),     8'h1);
                if (if_e.bit_en && if_e.tx_valid) z_e = z_e ^ if_e.tx_bit;
                if (if_o.bit_en && if_o.tx_valid) z_o = z_o ^ if_o.tx_bit;
            end
        end
        @(negedge clk);
        if_e.bit_en = 1'b0;
        chk("end_ready", 8'(if_e.in_ready), 8'h1);
        chk("end_valid", 8'(if_e.tx_valid), 8'h0);
        chk("end_busy",  8'(if_e.busy),     8'h0);
        chk("chk_even_z", 8'(z_e), 8'h0);
        chk("chk_odd_z",  8'(z_o), 8'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         p;

        vecs[0] = '{data: 8'hA5, period: 1, pe: 1'b0, po: 1'b1};
        vecs[1] = '{data: 8'h07, period: 1, pe: 1'b1, po: 1'b0};
        vecs[2] = '{data: 8'h00, period: 1, pe: 1'b0, po: 1'b1};
        vecs[3] = '{data: 8'h3C, period: 3, pe: 1'b0, po: 1'b1};
        vecs[4] = '{data: 8'h81, period: 2, pe: 1'b0, po: 1'b1};

        if_e.in_valid = 1'b0;
        if_e.in_data  = 8'h00;
        if_e.bit_en   = 1'b0;

        // Reset values, then bit_en in IDLE must do nothing
        #12;
        idle_chk("rst");
        @(negedge clk);
        reset = 1'b1;
        if_e.bit_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_chk("idle_en");
        end

        for (int i = 0; i < 5; i++) begin
            start(vecs[i].data);
            if_e.in_valid = 1'b0;
            body(vecs[i].data, vecs[i].period, vecs[i].pe, vecs[i].po);
        end

        // Asynchronous reset after three data bits of 8'hFF
        start(8'hFF);
        if_e.in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if_e.bit_en = 1'b1;
        end
        @(negedge clk);
        chk("pre_rst_valid", 8'(if_e.tx_valid), 8'h1);
        #2 reset = 1'b0;
        #1 idle_chk("async_rst");
        repeat (2) @(negedge clk);
        idle_chk("in_rst");
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_chk("post_rst");
        end
        start(8'h01);
        if_e.in_valid = 1'b0;
        body(8'h01, 1, 1'b1, 1'b0);

        // in_valid held high: second word waits, is taken in the first in_ready cycle
        start(8'h12);
        if_e.in_data = 8'h34;
        body(8'h12, 1, 1'b0, 1'b1);
        @(posedge clk);
        #1 if_e.in_valid = 1'b0;
        body(8'h34, 1, 1'b1, 1'b0);

        // Loopback into the checker model with random words
        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom_range(0, 255));
            p = $urandom_range(1, 2);
            start(d);
            if_e.in_valid = 1'b0;
            body(d, p, ^d, ~^d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
